// File: rtl/relu_pool_requant.sv
// relu_pool_requant: max-pools activation windows, requantizes the result
// with round-half-up and clamping, and queues it in a small output FIFO.
module relu_pool_requant #(
    parameter int IN_W   = 23,
    parameter int OUT_W  = 12,
    parameter int POOL_N = 4,
    parameter int SHIFT  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clear,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW    = (POOL_N > 1) ? $clog2(POOL_N) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int RND_I = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

    localparam logic [CW-1:0] LAST = CW'(POOL_N - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [IN_W:0] RND  = (IN_W + 1)'(RND_I);
    localparam logic [IN_W:0] MAXV = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [IN_W-1:0]  max_q, max_d;
    logic [OUT_W-1:0]        mem_q [DEPTH];
    logic [OUT_W-1:0]        mem_d [DEPTH];
    logic [AW-1:0]           rd_q, rd_d;
    logic [AW-1:0]           wr_q, wr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [OUT_W-1:0]        last_q, last_d;
    logic                    sat_q, sat_d;

    logic                    accept;
    logic                    close;
    logic                    push;
    logic                    pop;
    logic signed [IN_W-1:0]  in_s;
    logic signed [IN_W-1:0]  pool_max;
    logic [IN_W:0]           sum;
    logic [IN_W:0]           shifted;
    logic                    neg;
    logic                    sat_hit;
    logic [OUT_W-1:0]        res;

    // Handshakes; a simultaneous pop frees the slot a closing sample needs.
    always_comb begin
        in_ready  = (cnt_q != LAST) || (level_q < FULL) || out_ready;
        out_valid = (level_q != '0);
        accept    = in_valid && in_ready;
        close     = accept && (cnt_q == LAST);
        push      = close && !clear;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? mem_q[rd_q] : last_q;
        sat_flag  = sat_q;
        level     = level_q;
    end

    // Pooled value including the current sample, then round, shift, clamp.
    always_comb begin
        in_s     = $signed(in_data);
        pool_max = max_q;
        if (cnt_q == '0) begin
            pool_max = in_s;
        end else if (in_s > max_q) begin
            pool_max = in_s;
        end
        neg     = pool_max[IN_W-1];
        sum     = {pool_max[IN_W-1], pool_max} + RND;
        shifted = sum >> SHIFT;
        sat_hit = !neg && (shifted > MAXV);
        res     = shifted[OUT_W-1:0];
        if (neg) begin
            res = '0;
        end else if (sat_hit) begin
            res = MAXV[OUT_W-1:0];
        end
    end

    // Next-state for window tracking and the FIFO.
    always_comb begin
        cnt_d   = cnt_q;
        max_d   = max_q;
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;
        last_d  = last_q;
        sat_d   = sat_q;

        if (clear) begin
            cnt_d = '0;
            max_d = '0;
        end else if (accept) begin
            cnt_d = close ? '0 : cnt_q + CW'(1);
            max_d = pool_max;
        end

        if (push) begin
            mem_d[wr_q] = res;
            wr_d        = wr_q + AW'(1);
            sat_d       = sat_q | sat_hit;
        end

        if (pop) begin
            rd_d   = rd_q + AW'(1);
            last_d = mem_q[rd_q];
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            max_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            last_q  <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_relu_pool_requant.sv
// tb_relu_pool_requant: directed test of pooling, requantization,
// FIFO backpressure, reset and clear.
module tb_relu_pool_requant;

    logic        clk;
    logic        rst;
    logic [22:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    relu_pool_requant dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one edge, then deassert.
    task automatic feed(input int v);
        in_data  = 23'(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_sat", int'(sat_flag), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Basic window with rounding.
        out_ready = 1'b1;
        feed(10);
        feed(10);
        feed(10);
        chk("w1_not_yet", int'(out_valid), 0);
        feed(23);
        chk("w1_valid", int'(out_valid), 1);
        chk("w1_data", int'(out_data), 1);
        chk("w1_sat", int'(sat_flag), 0);
        idle(1);
        chk("w1_popped", int'(out_valid), 0);
        chk("w1_level", int'(level), 0);

        // Negative sample not the max; all-negative window clamps to 0.
        feed(160);
        feed(40);
        feed(0);
        feed(-66);
        chk("w2_data", int'(out_data), 10);
        feed(-5);
        feed(-1);
        feed(-66);
        feed(-2);
        chk("w3_valid", int'(out_valid), 1);
        chk("w3_data", int'(out_data), 0);

        // Saturation, then sticky flag.
        feed(40000);
        feed(0);
        feed(0);
        feed(0);
        chk("w4_data", int'(out_data), 2047);
        chk("w4_sat", int'(sat_flag), 1);
        feed(16);
        feed(0);
        feed(0);
        feed(0);
        chk("w5_data", int'(out_data), 1);
        chk("w5_sat", int'(sat_flag), 1);
        idle(1);
        chk("w5_empty", int'(level), 0);

        // Fill the FIFO with out_ready low.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            feed(16 * k);
            feed(0);
            feed(0);
            in_data  = '0;
            in_valid = 1'b1;
            #1;
            chk("fill_ready", int'(in_ready), 1);
            feed(0);
        end
        chk("full_level", int'(level), 4);
        feed(80);
        feed(0);
        feed(0);
        chk("full_nonclose_ok", int'(level), 4);
        in_data  = '0;
        in_valid = 1'b1;
        #1;
        chk("full_stall", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("stall_level", int'(level), 4);
        chk("stall_ready", int'(in_ready), 0);
        chk("stall_head", int'(out_data), 1);
        out_ready = 1'b1;
        #1;
        chk("pop_frees", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("swap_level", int'(level), 4);
        for (int k = 2; k <= 5; k++) begin
            chk("drain", int'(out_data), k);
            @(posedge clk);
            #1;
        end
        chk("drain_empty", int'(level), 0);
        chk("drain_hold", int'(out_data), 5);

        // Asynchronous reset mid-window with FIFO occupied.
        out_ready = 1'b0;
        feed(32);
        feed(0);
        feed(0);
        feed(0);
        chk("pre_rst_level", int'(level), 1);
        feed(800);
        feed(800);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_sat", int'(sat_flag), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        feed(16);
        feed(0);
        feed(0);
        feed(0);
        chk("post_rst_data", int'(out_data), 1);
        chk("post_rst_level", int'(level), 1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;

        // clear drops the partial window and the same-cycle sample.
        feed(48);
        feed(0);
        feed(0);
        feed(0);
        feed(1000);
        feed(1000);
        feed(1000);
        clear = 1'b1;
        feed(1000);
        clear = 1'b0;
        chk("clr_level", int'(level), 1);
        feed(32);
        feed(0);
        feed(0);
        feed(0);
        chk("clr_level2", int'(level), 2);
        chk("clr_head", int'(out_data), 3);
        out_ready = 1'b1;
        idle(1);
        chk("clr_next", int'(out_data), 2);
        idle(1);
        chk("clr_empty", int'(level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_pool_requant.md
Name: relu_pool_requant

Overview:
- Downstream stage of the neuron. It consumes the neuron's 23-bit signed activation stream.
- Max-pools each window of POOL_N consecutive valid samples.
- Requantizes the pooled value (round-half-up right shift, clamp to [0, 2047]) into the 12-bit signed format the next neuron layer takes on in_data.
- Buffers results in a small FIFO with a valid/ready output.

Parameters:
- IN_W, 23, input activation width (signed two's complement).
- OUT_W, 12, output width (signed two's complement; results are always ≥ 0).
- POOL_N, 4, samples per pooling window (≥ 1).
- SHIFT, 4, requantization right-shift amount (0..IN_W-1).
- DEPTH, 4, output FIFO depth (power of 2, ≥ 2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state while low.
- in_data  input  IN_W  neuron activation (signed).
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- clear  input  1  synchronous; discards the partial window; FIFO untouched.
- out_data  output  OUT_W  FIFO head value.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer takes out_data this cycle.
- sat_flag  output  1  sticky; a pooled value clamped at the upper bound since reset.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - count=0, running max=0.
  - FIFO empty: level=0, out_valid=0, out_data=0.
  - sat_flag=0.
  - in_ready=1 after release.
- Sample accept: in_valid && in_ready at a rising edge.
- Window count: count runs 0..POOL_N-1 and increments on each accept. It wraps to 0 on the accept at POOL_N-1.
- Running max (signed compare):
  - Sample at count=0 loads the max.
  - Later samples: max <= (in_data > max) ? in_data : max.
- Window close (accept at count=POOL_N-1):
  - p = signed max of running max and in_data, computed combinationally.
  - p < 0 → r = 0.
  - Otherwise r = (p + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed at IN_W+1 bits with no overflow.
  - r > 2^(OUT_W-1)-1 (2047) → r = 2047 and sat_flag <= 1.
  - r is written to the FIFO on the same edge.
- Latency: out_valid rises the cycle after the closing sample's accept edge (1 cycle), provided the FIFO was empty.
- in_ready = (count != POOL_N-1) || (level < DEPTH) || out_ready.
  - Non-closing samples are always accepted.
  - The out_ready → in_ready path is combinational (simultaneous pop frees a slot).
- FIFO behaviour:
  - Pop: out_valid && out_ready at an edge; head advances.
  - Simultaneous push and pop: level unchanged, order preserved.
  - Push into an empty FIFO while out_ready=1: the value is not bypassed; it appears next cycle.
  - Full (level=DEPTH) with no pop: the closing sample is stalled (in_ready=0). Running max and count hold.
  - out_data holds the head value while out_valid && !out_ready. When empty, out_data holds the last popped value (0 after reset).
- clear:
  - Sets count=0 and discards the running max.
  - A sample accepted in the same cycle as clear is dropped.
  - clear does not affect the FIFO or sat_flag.
- Pointers wrap modulo DEPTH; level distinguishes full from empty.
- sat_flag clears only on reset.

Test Plan:
- POOL_N=4, SHIFT=4. Feed 10,10,10,23 with out_ready=1 → one output 1, i.e. (23+8)>>4; out_valid high exactly 1 cycle after the 4th accept; sat_flag=0.
- Feed 160,40,0,-66 (23'h7FFFBE) → output 10. Feed a window of -5,-1,-66,-2 → output 0.
- Feed 40000,0,0,0 → output 2047, sat_flag=1. A following window of 16,0,0,0 → output 1, sat_flag stays 1.
- Hold out_ready=0 and feed 5 windows of 16·k (k=1..5) → level=4, in_ready low only at the 5th window's 4th sample.
  - Then hold out_ready=1 with the last sample present → same-edge pop and push.
  - Drain order is 1,2,3,4,5.
- Feed 2 samples (800,800), then pull rst low mid-cycle → outputs clear immediately (level=0, out_valid=0).
  - After release, window 16,0,0,0 → output 1 (no stale max).
- Feed 3 samples of 1000, pulse clear, then window 32,0,0,0 → a single output 2, FIFO contents from earlier windows intact.
